stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer that follows the plain 2:1 combinational mux.
- Each input and the output carry a valid/ready handshake.
- Channel choice is either round-robin arbitration or a fixed select input.
- The output is registered: one holding stage with full throughput. The block sits between multiple producer streams and a single consumer.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- CW, (N>1 ? $clog2(N) : 1), channel-index width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = round-robin, 1 = fixed select.
- sel  in  CW  channel index used when mode=1.
- in_valid  in  N  per-channel valid.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel ready. Combinational; at most one bit high.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data.
- out_ch  out  CW  source channel of out_data.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release) clears:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst is high.
- Load condition: load = !out_valid || out_ready.
- Grant, round-robin (mode=0):
  - Scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Grant the first channel with in_valid set.
- Grant, fixed (mode=1):
  - Grant sel when in_valid[sel]=1.
  - Never grant when sel>=N.
- in_ready[g]=1 only when load=1, a grant exists, and g is the granted channel. All other in_ready bits are 0.
- Transfer on channel g (in_valid[g] && in_ready[g]) at a clock edge:
  - out_data <= data of channel g.
  - out_ch <= g.
  - out_valid <= 1.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready stays high.
- Output drain: out_valid && out_ready with no new transfer gives out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and transfer in the same cycle: the new word replaces the old one, out_valid stays 1, and no bubble is inserted.
- Stall: while out_valid && !out_ready, out_data and out_ch stay stable and all in_ready are 0.
- Pointer update:
  - On a transfer in mode=0: ptr <= (g==N-1) ? 0 : g+1.
  - In mode=1: ptr is unchanged.
- Mode or sel changes take effect on the next grant evaluation. A word already held is unaffected.
- in_valid without grant: a producer keeps its data until accepted. The block never drops an accepted word.
- Reset mid-stream: a held word is discarded and ptr returns to 0.

Decomposition:
- Package stream_mux_pkg holds:
  - Constants MODE_RR=1'b0 and MODE_FIXED=1'b1.
  - A function computing CW from N.
- Sub-module rr_arbiter (purely combinational):
  - Parameter N.
  - Inputs req[N] and ptr[CW].
  - Outputs gnt_valid and gnt_idx[CW].
- The top level instantiates rr_arbiter and owns:
  - the fixed-select path,
  - the mode mux,
  - the output register,
  - ptr.

Test Plan:
- Reset/idle, N=4 W=8: assert rst mid-cycle with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately, not at the next edge. After release, no in_valid -> out_valid stays 0.
- Round-robin fairness: mode=0, all four in_valid=1 with data 8'hA0..8'hA3, out_ready=1 -> out_ch sequence 0,1,2,3,0, one word per cycle, out_data matches the source channel.
- Sparse round-robin with wrap: after a grant on ch2, only ch1 and ch3 valid -> ch3 granted, then ch1 (pointer wrap).
- Fixed select: mode=1, sel=2, all valid -> only in_ready[2] pulses and out_ch=2 every cycle. With sel=2 and in_valid[2]=0 -> no transfer and out_valid falls.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 and out_data=8'h55 -> out_data stays 8'h55 and in_ready=0. When out_ready returns to 1, the next word loads in the same cycle with no bubble.
- Out-of-range select: N=3 build, mode=1, sel=3 -> in_ready stays all 0 and out_valid stays 0. Switching to mode=0 resumes round-robin from the current ptr.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr block.
// Mode encodings and the channel-index width function.
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after
// ptr, wrapping around, wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [cw_of(N)-1:0]  ptr,
  output logic                 gnt_valid,
  output logic [cw_of(N)-1:0]  gnt_idx
);

  localparam int CW = cw_of(N);

  int idx;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or fixed select
// and a single full-throughput output register.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CW    = cw_of(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [CW-1:0]        sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_ch,
  input  logic                 out_ready
);

  logic             load;
  logic             rr_valid;
  logic             fx_valid;
  logic             gnt_valid;
  logic             xfer;
  logic [CW-1:0]    rr_idx;
  logic [CW-1:0]    gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic [CW-1:0]    ptr_q, ptr_d;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    fx_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == CW'(i) && in_valid[i]) begin
        fx_valid = 1'b1;
      end
    end
  end

  assign gnt_valid = (mode == MODE_FIXED) ? fx_valid : rr_valid;
  assign gnt_idx   = (mode == MODE_FIXED) ? sel : rr_idx;
  assign load      = !out_valid_q || out_ready;
  assign xfer      = load && gnt_valid && !rst;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == CW'(i)) begin
        in_ready[i] = xfer;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: N=4 main instance plus an N=3
// instance for the out-of-range select case.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  iv3;
  logic [23:0] id3;
  logic [2:0]  ir3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  och3;
  logic        ordy3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] chq [4][$];
  logic [9:0] sbq [$];
  logic [9:0] q3  [$];
  logic [3:0] hs;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .WIDTH(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.N(3), .WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (iv3),
    .in_data   (id3),
    .in_ready  (ir3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_ch    (och3),
    .out_ready (ordy3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input int ch, input logic [7:0] d);
    chq[ch].push_back(d);
  endtask

  task automatic exp4(input int ch, input logic [7:0] d);
    sbq.push_back({2'(ch), d});
  endtask

  task automatic exp3(input int ch, input logic [7:0] d);
    q3.push_back({2'(ch), d});
  endtask

  // Producers: hold each word until the handshake completes.
  initial begin
    in_valid = '0;
    in_data  = '0;
    hs       = '0;
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) void'(chq[i].pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        in_valid[i] = (chq[i].size() != 0);
        if (in_valid[i]) in_data[i*8 +: 8] = chq[i][0];
      end
      #6;
      hs = in_valid & in_ready;
    end
  end

  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #9;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total_cnt++;
          $display("FAIL sb4 unexpected word: got %0h expected none",
                   {out_ch, out_data});
        end else begin
          e = sbq.pop_front();
          chk("sb4 word", {22'd0, out_ch, out_data}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #9;
      if (ov3 && ordy3) begin
        if (q3.size() == 0) begin
          total_cnt++;
          $display("FAIL sb3 unexpected word: got %0h expected none",
                   {och3, od3});
        end else begin
          e = q3.pop_front();
          chk("sb3 word", {22'd0, och3, od3}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    mode3     = 1'b1;
    sel3      = 2'd3;
    iv3       = 3'b000;
    id3       = {8'h33, 8'h32, 8'h31};
    ordy3     = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    sync();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle out_valid", out_valid, 0);
    end

    sync();
    for (int i = 0; i < 4; i++) send(i, 8'hA0 + 8'(i));
    send(0, 8'hA0);
    exp4(0, 8'hA0); exp4(1, 8'hA1); exp4(2, 8'hA2);
    exp4(3, 8'hA3); exp4(0, 8'hA0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr stream valid", out_valid, 1);
    end
    @(negedge clk);
    chk("rr drained", out_valid, 0);

    idle(2);
    sync();
    send(2, 8'hC2);
    exp4(2, 8'hC2);
    idle(3);
    sync();
    send(1, 8'hC1);
    send(3, 8'hC3);
    exp4(3, 8'hC3);
    exp4(1, 8'hC1);
    idle(4);

    sync();
    mode = 1'b1;
    sel  = 2'd2;
    send(0, 8'hD0); send(1, 8'hD1); send(3, 8'hD3);
    send(2, 8'hD4); send(2, 8'hD5); send(2, 8'hD6);
    exp4(2, 8'hD4); exp4(2, 8'hD5); exp4(2, 8'hD6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fixed in_ready", in_ready, 4'b0100);
    end
    @(negedge clk);
    chk("fixed ch2 empty ready", in_ready, 0);
    @(negedge clk);
    chk("fixed valid falls", out_valid, 0);
    chk("fixed no grant", in_ready, 0);

    sync();
    out_ready = 1'b0;
    send(2, 8'h55);
    send(2, 8'h66);
    exp4(2, 8'h55);
    exp4(2, 8'h66);
    @(negedge clk);
    chk("bp first load", in_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp hold data", out_data, 8'h55);
      chk("bp hold valid", out_valid, 1);
      chk("bp hold ready", in_ready, 0);
    end
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp release ready", in_ready, 4'b0100);
    @(negedge clk);
    chk("bp next word", out_data, 8'h66);
    chk("bp no bubble", out_valid, 1);

    sync();
    mode = 1'b0;
    exp4(3, 8'hD3); exp4(0, 8'hD0); exp4(1, 8'hD1);
    idle(6);

    sync();
    out_ready = 1'b0;
    send(1, 8'hF1);
    send(3, 8'hF3);
    exp4(1, 8'hF1);
    @(negedge clk);
    @(negedge clk);
    chk("held ch", out_ch, 3);
    chk("held valid", out_valid, 1);
    #2;
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst out_ch", out_ch, 0);
    chk("midrst in_ready", in_ready, 0);
    sync();
    rst = 1'b0;
    idle(4);

    sync();
    iv3 = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("oor in_ready", ir3, 0);
      chk("oor out_valid", ov3, 0);
    end
    sync();
    mode3 = 1'b0;
    exp3(0, 8'h31); exp3(1, 8'h32); exp3(2, 8'h33);
    @(negedge clk);
    chk("n3 rr ready0", ir3, 3'b001);
    @(negedge clk);
    chk("n3 rr ready1", ir3, 3'b010);
    @(negedge clk);
    chk("n3 rr ready2", ir3, 3'b100);
    sync();
    iv3 = 3'b000;

    for (int k = 0; k < 50; k++) begin
      if (sbq.size() == 0 && q3.size() == 0 && !out_valid && !ov3) break;
      @(posedge clk);
    end
    idle(2);
    chk("scoreboard drained", sbq.size() + q3.size(), 0);
    chk("final out_valid", {ov3, out_valid}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
